// File: rtl/transpose_pkg.sv
// Shared types and helpers for the ping-pong transpose frame-RAM scheduler.
package transpose_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int unsigned DEF_ROW     = 64;
    localparam int unsigned DEF_CLO     = 2400;
    localparam int unsigned FRAME_WORDS = DEF_ROW * DEF_CLO;

    // Bank 1 sits directly above bank 0 in the shared address space.
    function automatic logic [31:0] bank_base(input logic sel, input int unsigned words);
        return sel ? 32'(words) : 32'd0;
    endfunction

endpackage

// File: rtl/pp_bank_fsm.sv
// Lifecycle of one frame bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pp_bank_fsm
    import transpose_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_wr_i,
    input  logic       fin_wr_i,
    input  logic       start_rd_i,
    input  logic       fin_rd_i,
    output logic [1:0] state_o,
    output logic       fault_o
);

    bank_state_t state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:    if (start_wr_i) state_d = FILLING;
            FILLING:  if (fin_wr_i)   state_d = FULL;
            FULL:     if (start_rd_i) state_d = DRAINING;
            DRAINING: if (fin_rd_i)   state_d = EMPTY;
            default:                  state_d = EMPTY;
        endcase
    end

    // A finish pulse that does not match this bank's activity changes nothing but is flagged.
    assign fault_o = (fin_wr_i && (state_q != FILLING)) || (fin_rd_i && (state_q != DRAINING));
    assign state_o = state_q;

endmodule

// File: rtl/transpose_pingpong_sched.sv
// Ping-pong bank scheduler: grants frames to free banks, then drains full banks in order.
module transpose_pingpong_sched
    import transpose_pkg::*;
#(
    parameter int unsigned ROW        = DEF_ROW,
    parameter int unsigned CLO        = DEF_CLO,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_req,
    output logic                  frame_ack,
    output logic                  wr_command,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH:0]   wr_base,
    input  logic                  wr_finish,
    input  logic                  rd_hold,
    output logic                  rd_command,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH:0]   rd_base,
    input  logic                  rd_finish,
    output logic [1:0]            bank_full,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_done,
    output logic                  err_spurious
);

    localparam int unsigned BaseW     = ADDR_WIDTH + 1;
    localparam int unsigned FrameSize = ROW * CLO;

    logic [1:0] bank_st [2];
    logic [1:0] start_wr, fin_wr, start_rd, fin_rd, fault;

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 wr_cmd_q, rd_cmd_q;
    logic [CNT_WIDTH-1:0] frames_q, frames_d;
    logic                 err_q, err_d;
    logic                 any_filling, any_draining;
    logic                 wr_go, rd_go, wr_fin_ok, rd_fin_ok;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_fsm u_bank (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .start_wr_i (start_wr[b]),
            .fin_wr_i   (fin_wr[b]),
            .start_rd_i (start_rd[b]),
            .fin_rd_i   (fin_rd[b]),
            .state_o    (bank_st[b]),
            .fault_o    (fault[b])
        );
    end

    // Start conditions see only registered bank states, so finish pulses never bypass.
    always_comb begin
        any_filling  = (bank_st[0] == FILLING)  || (bank_st[1] == FILLING);
        any_draining = (bank_st[0] == DRAINING) || (bank_st[1] == DRAINING);
        wr_go     = frame_req && (bank_st[wr_bank_q] == EMPTY) && !any_filling;
        rd_go     = !rd_hold && (bank_st[rd_bank_q] == FULL) && !any_draining;
        wr_fin_ok = wr_finish && (bank_st[wr_bank_q] == FILLING);
        rd_fin_ok = rd_finish && (bank_st[rd_bank_q] == DRAINING);

        start_wr = 2'b00;
        fin_wr   = 2'b00;
        start_rd = 2'b00;
        fin_rd   = 2'b00;
        start_wr[wr_bank_q] = wr_go;
        fin_wr[wr_bank_q]   = wr_finish;
        start_rd[rd_bank_q] = rd_go;
        fin_rd[rd_bank_q]   = rd_finish;

        wr_bank_d = wr_bank_q ^ wr_fin_ok;
        rd_bank_d = rd_bank_q ^ rd_fin_ok;
        frames_d  = frames_q + CNT_WIDTH'(rd_fin_ok);
        err_d     = err_q | (|fault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cmd_q  <= 1'b0;
            rd_cmd_q  <= 1'b0;
            frames_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cmd_q  <= wr_go;
            rd_cmd_q  <= rd_go;
            frames_q  <= frames_d;
            err_q     <= err_d;
        end
    end

    assign frame_ack    = wr_cmd_q;
    assign wr_command   = wr_cmd_q;
    assign rd_command   = rd_cmd_q;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = rd_bank_q;
    assign wr_base      = BaseW'(bank_base(wr_bank_q, FrameSize));
    assign rd_base      = BaseW'(bank_base(rd_bank_q, FrameSize));
    assign bank_full[0] = bank_st[0][1];
    assign bank_full[1] = bank_st[1][1];
    assign busy         = (bank_st[0] != EMPTY) || (bank_st[1] != EMPTY);
    assign frames_done  = frames_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_transpose_pingpong_sched.sv
// Directed bench for the ping-pong scheduler with a queued pulse scoreboard.
module tb_transpose_pingpong_sched;

    localparam int unsigned AW   = 18;
    localparam int unsigned CW   = 4;
    localparam int unsigned BASE1 = 153600;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          frame_req = 1'b0, wr_finish = 1'b0, rd_hold = 1'b0, rd_finish = 1'b0;
    logic          frame_ack, wr_command, wr_bank, rd_command, rd_bank, busy, err_spurious;
    logic [AW:0]   wr_base, rd_base;
    logic [1:0]    bank_full;
    logic [CW-1:0] frames_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        bit wr;
        bit rd;
        bit wb;
        bit rb;
    } exp_t;
    exp_t exp_q[$];

    transpose_pingpong_sched #(
        .ROW        (64),
        .CLO        (2400),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_req    (frame_req),
        .frame_ack    (frame_ack),
        .wr_command   (wr_command),
        .wr_bank      (wr_bank),
        .wr_base      (wr_base),
        .wr_finish    (wr_finish),
        .rd_hold      (rd_hold),
        .rd_command   (rd_command),
        .rd_bank      (rd_bank),
        .rd_base      (rd_base),
        .rd_finish    (rd_finish),
        .bank_full    (bank_full),
        .busy         (busy),
        .frames_done  (frames_done),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses land on the edge after the inputs that cause them are set up.
    task automatic expect_pulse(input bit wr, input bit rd, input bit wb, input bit rb);
        exp_t e;
        e.cyc = cyc + 1;
        e.wr  = wr;
        e.rd  = rd;
        e.wb  = wb;
        e.rb  = rb;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_ack || wr_command || rd_command)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {frame_ack, wr_command, rd_command}, 3'b000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                chk("wr_command", wr_command, e.wr);
                chk("frame_ack", frame_ack, e.wr);
                chk("rd_command", rd_command, e.rd);
                if (e.wr) begin
                    chk("wr_bank", wr_bank, e.wb);
                    chk("wr_base", wr_base, e.wb ? BASE1 : 0);
                end
                if (e.rd) begin
                    chk("rd_bank", rd_bank, e.rb);
                    chk("rd_base", rd_base, e.rb ? BASE1 : 0);
                end
            end
        end
    end

    initial begin
        bit b;
        #2 rst_n = 1'b0;
        step(2);
        chk("rst_outputs", {frame_ack, wr_command, rd_command, wr_bank, rd_bank, busy, err_spurious},
            7'b0);
        chk("rst_bases", {wr_base, rd_base}, 0);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_frames_done", frames_done, 0);
        rst_n = 1'b1;
        step(1);

        // First frame into bank 0; holding frame_req must not re-trigger.
        frame_req = 1'b1;
        expect_pulse(1, 0, 0, 0);
        step(7);
        chk("filling_busy", busy, 1'b1);
        chk("filling_bank_full", bank_full, 2'b00);
        wr_finish = 1'b1;
        step(1);
        wr_finish = 1'b0;
        chk("b0_full", bank_full, 2'b01);
        chk("wr_bank_toggle", wr_bank, 1'b1);
        chk("wr_base_bank1", wr_base, BASE1);
        chk("rd_bank_still0", rd_bank, 1'b0);
        // Read of bank 0 and write of bank 1 start together.
        expect_pulse(1, 1, 1, 0);
        step(1);
        chk("overlap_bank_full", bank_full, 2'b01);
        frame_req = 1'b0;
        step(3);
        rd_finish = 1'b1;
        step(1);
        rd_finish = 1'b0;
        chk("frames_done_1", frames_done, 1);
        chk("rd_bank_1", rd_bank, 1'b1);
        chk("after_drain_full", bank_full, 2'b00);

        // Backpressure: hold reads off until both banks are full.
        rd_hold = 1'b1;
        frame_req = 1'b1;
        wr_finish = 1'b1;
        step(1);
        wr_finish = 1'b0;
        expect_pulse(1, 0, 0, 1);
        step(1);
        chk("b1_full_b0_fill", bank_full, 2'b10);
        wr_finish = 1'b1;
        step(1);
        wr_finish = 1'b0;
        chk("both_full", bank_full, 2'b11);
        step(50);
        chk("both_full_wait", bank_full, 2'b11);
        chk("no_err_backpressure", err_spurious, 1'b0);
        rd_hold = 1'b0;
        expect_pulse(0, 1, 1, 1);
        step(1);
        chk("draining_counts_full", bank_full, 2'b11);
        rd_finish = 1'b1;
        step(1);
        rd_finish = 1'b0;
        chk("frames_done_2", frames_done, 2);
        expect_pulse(1, 1, 1, 0);
        step(1);

        // Simultaneous finishes on different banks.
        wr_finish = 1'b1;
        rd_finish = 1'b1;
        step(1);
        wr_finish = 1'b0;
        rd_finish = 1'b0;
        chk("simul_bank_full", bank_full, 2'b10);
        chk("frames_done_3", frames_done, 3);
        expect_pulse(1, 1, 0, 1);
        step(1);
        frame_req = 1'b0;
        step(2);
        chk("pre_reset_full", bank_full, 2'b10);
        chk("pre_reset_busy", busy, 1'b1);

        // Asynchronous reset mid-frame.
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", {busy, bank_full, wr_bank, rd_bank, wr_command, rd_command}, 7'b0);
        chk("async_rst_frames", frames_done, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Serial frames until the counter wraps.
        b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            frame_req = 1'b1;
            expect_pulse(1, 0, b, b);
            step(1);
            frame_req = 1'b0;
            wr_finish = 1'b1;
            step(1);
            wr_finish = 1'b0;
            expect_pulse(0, 1, ~b, b);
            step(1);
            rd_finish = 1'b1;
            step(1);
            rd_finish = 1'b0;
            chk("frames_done_serial", frames_done, (i + 1) % 16);
            b = ~b;
        end

        // Spurious rd_finish with every bank empty.
        rd_finish = 1'b1;
        step(1);
        rd_finish = 1'b0;
        chk("spurious_err", err_spurious, 1'b1);
        chk("spurious_state", {busy, bank_full, rd_bank}, 4'b0);
        chk("spurious_frames", frames_done, 0);
        step(5);
        chk("spurious_sticky", err_spurious, 1'b1);

        step(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
